// File: rtl/calc_pkg.sv
// Shared calculator definitions: multiplier FSM states and operation codes.
// Used by the multiplier and adder paths; no ports.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mult_state_t;

  localparam logic [1:0] SEL_ADDU = 2'b00;
  localparam logic [1:0] SEL_ADDS = 2'b01;
  localparam logic [1:0] SEL_MULT = 2'b10;
  localparam logic [1:0] SEL_SQR  = 2'b11;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level command.
// Ports: clk, resetN (sync, active-low), in (level), rise (1-cycle pulse).
module rise_detect (
  input  logic clk,
  input  logic resetN,
  input  logic in,
  output logic rise
);

  logic prev;

  // prev resets high so a level held across reset release is not an edge
  always_ff @(posedge clk) begin
    if (!resetN) prev <= 1'b1;
    else         prev <= in;
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle unsigned shift-add multiplier (multiply / square).
// Ports: clk, resetN, enter, sel, a, b in; product, busy, done out.
module seq_multiplier
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               enter,
  input  logic [1:0]         sel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t state, state_nxt;

  logic               enter_rise;
  logic               start;
  logic               last;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  rise_detect u_rise (
    .clk    (clk),
    .resetN (resetN),
    .in     (enter),
    .rise   (enter_rise)
  );

  assign start   = enter_rise & sel[1] & (state == IDLE);
  assign last    = (cnt == LAST);
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= (sel == SEL_SQR) ? a : b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // final partial product folded in directly
          if (last) product <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
